sync_instruction_memory: RTL

SYNC_INSTRUCTION_MEMORY -- requirements
Module: sync_instruction_memory

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_array.sv | 26 ++
 rtl/sync_instruction_memory.sv | 121 ++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// Holds the controller state encoding, NOP default and pc legality check.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Word aligned and no address bits above the array range.
  function automatic logic pc_legal(
    input logic [31:0] pc,
    input int unsigned aw
  );
    logic [31:0] hi;
    hi = pc >> (aw + 2);
    return (pc[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Contents are never reset so a program survives reset.
module imem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_instruction_memory.sv
// Instruction memory with fetch port (stall/flush/fault) and a
// streaming program-load port feeding the same array.
module sync_instruction_memory
  import imem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] NOP_WORD   = NOP_DEFAULT,
  parameter bit          PRELOAD    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           pc,
  input  logic                  fetch_en,
  input  logic                  stall,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  output logic                  fetch_fault,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  loading,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  imem_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  src_mem_q;
  logic                  valid_q;
  logic                  fault_q;
  logic [31:0]           rdata;
  logic                  start;
  logic                  acc;
  logic                  legal;
  logic                  run_ok;
  logic                  re;

  assign start  = load_start && (state_q != LOAD);
  assign acc    = (state_q == LOAD) && load_valid;
  assign legal  = pc_legal(pc, ADDR_WIDTH);
  assign run_ok = (state_q == RUN) && !start;
  assign re     = run_ok && !flush && !stall && fetch_en && legal;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RUN: if (load_start) state_d = LOAD;
      LOAD:      if (acc && load_last) state_d = RUN;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (PRELOAD) state_q <= RUN;
      else         state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      wptr_q <= load_base;
      cnt_q  <= '0;
    end else if (acc) begin
      wptr_q <= wptr_q + ADDR_WIDTH'(1);
      if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + (ADDR_WIDTH + 1)'(1);
    end
  end

  // The array read register holds its word while stalled, so only the
  // source select and flags need to be tracked here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_mem_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else if (!run_ok || flush) begin
      src_mem_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else if (!stall) begin
      src_mem_q <= re;
      valid_q   <= fetch_en;
      fault_q   <= fetch_en && !legal;
    end
  end

  imem_array #(
    .AW(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (acc),
    .waddr(wptr_q),
    .wdata(load_data),
    .re   (re),
    .raddr(pc[ADDR_WIDTH+1:2]),
    .rdata(rdata)
  );

  assign instruction = src_mem_q ? rdata : NOP_WORD;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;
  assign load_ready  = (state_q == LOAD);
  assign loading     = (state_q == LOAD);
  assign load_count  = cnt_q;

endmodule
